// File: rtl/comm_pkg.sv
// Shared widths, default sync header and scheduler state encoding for the
// PCM -> Hamming -> frame -> FSK transmit chain.
package comm_pkg;

  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned CODE_W   = 12;
  localparam int unsigned SYNC_W   = 4;
  localparam int unsigned FRAME_W  = 16;

  localparam logic [SYNC_W-1:0] SYNC_WORD_DEF = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENCODE,
    ST_SHIFT,
    ST_GAP
  } sched_state_e;

endpackage

// File: rtl/tx_frame_scheduler_bit_timer.sv
// Bit-period divider: bit_tick on the first cycle of each bit, bit_end on the
// last, and a 0..15 bit index. Synchronous clear restarts phase and index.
module bit_timer #(
  parameter int unsigned BIT_DIV = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  output logic       bit_tick_o,
  output logic       bit_end_o,
  output logic [3:0] bit_idx_o
);

  localparam int unsigned DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);

  logic [DW-1:0] div_q;
  logic [3:0]    idx_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      div_q <= '0;
      idx_q <= '0;
    end else if (en_i) begin
      if (div_q == DIV_LAST) begin
        div_q <= '0;
        idx_q <= idx_q + 4'd1;
      end else begin
        div_q <= div_q + DW'(1);
      end
    end
  end

  assign bit_tick_o = en_i && (div_q == '0);
  assign bit_end_o  = en_i && (div_q == DIV_LAST);
  assign bit_idx_o  = idx_q;

endmodule

// File: rtl/tx_frame_scheduler.sv
// Transmit sequencer: sample handshake, encoder launch, sync+codeword framing
// and MSB-first serialisation. Optional one-entry prefetch: SCHED_PREFETCH_EN.
module tx_frame_scheduler
  import comm_pkg::*;
#(
  parameter int unsigned       BIT_DIV   = 16,
  parameter int unsigned       PIPE_LAT  = 2,
  parameter int unsigned       IDLE_BITS = 0,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_WORD_DEF
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_data,
  output logic                enc_start,
  output logic [SAMPLE_W-1:0] enc_data,
  input  logic [CODE_W-1:0]   enc_code,
  output logic                tx_bit,
  output logic                tx_bit_valid,
  output logic                bit_tick,
  output logic                busy,
  output logic                frame_done,
  output logic [15:0]         frame_count
);

  sched_state_e         state_q, done_state_d;
  logic [SAMPLE_W-1:0]  enc_data_q;
  logic                 enc_start_q, frame_done_q, tx_valid_q;
  logic [FRAME_W-1:0]   shreg_q;
  logic [15:0]          frame_cnt_q, gap_q;
  logic [7:0]           enc_cnt_q;
  logic                 accept, timer_en, bit_end, tick, enc_last, gap_last;
  logic [3:0]           bit_idx;

`ifdef SCHED_PREFETCH_EN
  logic [SAMPLE_W-1:0]  buf_q;
  logic                 buf_full_q, pend_q, drain;
  assign s_ready = !sys_rst && ((state_q == ST_IDLE) || !buf_full_q);
  assign drain   = buf_full_q || accept;
`else
  assign s_ready = !sys_rst && (state_q == ST_IDLE);
`endif

  assign accept   = s_valid && s_ready;
  assign timer_en = (state_q == ST_SHIFT) || (state_q == ST_GAP);
  assign enc_last = (32'(enc_cnt_q) == PIPE_LAT - 32'd1);
  assign gap_last = (32'(gap_q) + 32'd1 == IDLE_BITS);

  always_comb begin
    done_state_d = ST_IDLE;
`ifdef SCHED_PREFETCH_EN
    if (drain) done_state_d = ST_ENCODE;
`endif
  end

  // Timer is held clear outside SHIFT/GAP, so each frame starts at phase 0.
  bit_timer #(.BIT_DIV(BIT_DIV)) u_bit_timer (
    .clk_i      (sys_clk),
    .rst_i      (sys_rst),
    .clr_i      (!timer_en),
    .en_i       (timer_en),
    .bit_tick_o (tick),
    .bit_end_o  (bit_end),
    .bit_idx_o  (bit_idx)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      enc_data_q   <= '0;
      enc_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
      tx_valid_q   <= 1'b0;
      shreg_q      <= '0;
      frame_cnt_q  <= '0;
      gap_q        <= '0;
      enc_cnt_q    <= '0;
`ifdef SCHED_PREFETCH_EN
      buf_q        <= '0;
      buf_full_q   <= 1'b0;
      pend_q       <= 1'b0;
`endif
    end else begin
      enc_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef SCHED_PREFETCH_EN
      if (accept && state_q != ST_IDLE) begin
        buf_q      <= s_data;
        buf_full_q <= 1'b1;
      end
`endif
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            enc_data_q  <= s_data;
            enc_start_q <= 1'b1;
            enc_cnt_q   <= '0;
            state_q     <= ST_ENCODE;
          end
        end
        ST_ENCODE: begin
`ifdef SCHED_PREFETCH_EN
          // Completion cycle with a buffered sample: drain it, launch next cycle.
          if (pend_q) begin
            pend_q      <= 1'b0;
            enc_data_q  <= buf_q;
            buf_full_q  <= 1'b0;
            enc_start_q <= 1'b1;
            enc_cnt_q   <= '0;
          end else
`endif
          if (enc_last) begin
            shreg_q    <= {SYNC_WORD, enc_code};
            tx_valid_q <= 1'b1;
            state_q    <= ST_SHIFT;
          end else begin
            enc_cnt_q <= enc_cnt_q + 8'd1;
          end
        end
        ST_SHIFT: begin
          if (bit_end) begin
            shreg_q <= {shreg_q[FRAME_W-2:0], 1'b0};
            if (bit_idx == 4'd15) begin
              tx_valid_q <= 1'b0;
              if (IDLE_BITS > 0) begin
                gap_q   <= '0;
                state_q <= ST_GAP;
              end else begin
                frame_done_q <= 1'b1;
                frame_cnt_q  <= frame_cnt_q + 16'd1;
                state_q      <= done_state_d;
`ifdef SCHED_PREFETCH_EN
                pend_q       <= drain;
`endif
              end
            end
          end
        end
        ST_GAP: begin
          if (bit_end) begin
            if (gap_last) begin
              frame_done_q <= 1'b1;
              frame_cnt_q  <= frame_cnt_q + 16'd1;
              state_q      <= done_state_d;
`ifdef SCHED_PREFETCH_EN
              pend_q       <= drain;
`endif
            end else begin
              gap_q <= gap_q + 16'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign enc_start    = enc_start_q;
  assign enc_data     = enc_data_q;
  assign tx_bit       = shreg_q[FRAME_W-1] && tx_valid_q;
  assign tx_bit_valid = tx_valid_q;
  assign bit_tick     = tick;
  assign busy         = (state_q != ST_IDLE);
  assign frame_done   = frame_done_q;
  assign frame_count  = frame_cnt_q;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed bench for tx_frame_scheduler: table of single frames plus
// back-pressure/prefetch, mid-frame reset, count wrap and idle-gap sequences.
module tb_tx_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0, s_ready;
  logic [7:0]  s_data = '0, enc_data;
  logic        enc_start, tx_bit, tx_bit_valid, bit_tick, busy, frame_done;
  logic [11:0] enc_code = '0;
  logic [15:0] frame_count;

  logic        g_s_valid = 1'b0, g_s_ready;
  logic [7:0]  g_s_data = '0, g_enc_data;
  logic        g_enc_start, g_tx_bit, g_tx_bit_valid, g_bit_tick, g_busy, g_frame_done;
  logic [11:0] g_enc_code = 12'hABC;
  logic [15:0] g_frame_count;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  tx_frame_scheduler #(.BIT_DIV(16), .PIPE_LAT(2), .IDLE_BITS(0)) dut (
    .sys_clk(clk), .sys_rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .enc_start(enc_start), .enc_data(enc_data), .enc_code(enc_code), .tx_bit(tx_bit),
    .tx_bit_valid(tx_bit_valid), .bit_tick(bit_tick), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  tx_frame_scheduler #(.BIT_DIV(16), .PIPE_LAT(2), .IDLE_BITS(2)) dut_gap (
    .sys_clk(clk), .sys_rst(rst), .s_valid(g_s_valid), .s_ready(g_s_ready), .s_data(g_s_data),
    .enc_start(g_enc_start), .enc_data(g_enc_data), .enc_code(g_enc_code), .tx_bit(g_tx_bit),
    .tx_bit_valid(g_tx_bit_valid), .bit_tick(g_bit_tick), .busy(g_busy),
    .frame_done(g_frame_done), .frame_count(g_frame_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    else passed++;
  endtask

  // Cycle 0 is the accept cycle; outputs sampled at the negedge of cycle c.
  task automatic run_frame(input logic [7:0] smp, input logic [11:0] code,
                           input logic [15:0] exp_frame, input logic [15:0] exp_cnt);
    logic [15:0] got;
    got = '0;
    @(negedge clk);
    chk("ready_idle", s_ready, 1);
    s_valid = 1'b1; s_data = smp; enc_code = code;
    for (int c = 1; c <= 260; c++) begin
      @(negedge clk);
      if (c == 1) begin
        s_valid = 1'b0;
        chk("enc_start_c1", enc_start, 1);
        chk("enc_data", enc_data, smp);
        chk("busy_c1", busy, 1);
      end
      if (c == 2) begin
        chk("enc_start_c2", enc_start, 0);
        chk("txv_c2", tx_bit_valid, 0);
      end
      if (c == 3) begin
        chk("txv_c3", tx_bit_valid, 1);
        chk("tick_c3", bit_tick, 1);
        enc_code = ~code;
      end
      if (c == 4)  chk("tick_c4", bit_tick, 0);
      if (c == 19) chk("tick_c19", bit_tick, 1);
      if (c >= 3 && c <= 258 && ((c - 3) % 16) == 8) got = {got[14:0], tx_bit};
      if (c == 258) begin
        chk("txv_c258", tx_bit_valid, 1);
        chk("done_c258", frame_done, 0);
      end
      if (c == 259) begin
        chk("done_c259", frame_done, 1);
        chk("txv_c259", tx_bit_valid, 0);
        chk("busy_c259", busy, 0);
        chk("frame_count", frame_count, exp_cnt);
      end
      if (c == 260) chk("done_c260", frame_done, 0);
    end
    chk("frame_bits", got, exp_frame);
  endtask

  task automatic wait_done(input int lim, input logic [15:0] exp_cnt);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1'b1;
        chk("count_at_done", frame_count, exp_cnt);
      end
    end
    chk("done_within_bound", seen, 1);
  endtask

  typedef struct {
    logic [7:0]  smp;
    logic [11:0] code;
    logic [15:0] frame;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int bad, ticks;
    vecs[0] = '{smp: 8'h5A, code: 12'hABC, frame: 16'hBABC};
    vecs[1] = '{smp: 8'h00, code: 12'h000, frame: 16'hB000};
    vecs[2] = '{smp: 8'hFF, code: 12'hFFF, frame: 16'hBFFF};
    vecs[3] = '{smp: 8'hC3, code: 12'h5A3, frame: 16'hB5A3};

    repeat (2) @(negedge clk);
    chk("rst_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", frame_count, 0);
    chk("rst_txv", tx_bit_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", s_ready, 1);

    for (int i = 0; i < 4; i++)
      run_frame(vecs[i].smp, vecs[i].code, vecs[i].frame, 16'(i + 1));

    // Source keeps s_valid high across the whole first frame.
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'h11; enc_code = 12'h123;
    bad = 0;
    for (int c = 1; c <= 262; c++) begin
      @(negedge clk);
      if (c == 1) s_data = 8'h22;
`ifdef SCHED_PREFETCH_EN
      if (c == 1) chk("pf_ready_c1", s_ready, 1);
      if (c == 2) begin
        s_valid = 1'b0;
        chk("pf_ready_full", s_ready, 0);
      end
      if (!busy) bad++;
      if (c == 259) begin
        chk("pf_done", frame_done, 1);
        chk("pf_txv_259", tx_bit_valid, 0);
        chk("pf_start_259", enc_start, 0);
      end
      if (c == 260) begin
        chk("pf_start_260", enc_start, 1);
        chk("pf_data_260", enc_data, 8'h22);
      end
      if (c == 261) chk("pf_txv_261", tx_bit_valid, 0);
      if (c == 262) chk("pf_txv_262", tx_bit_valid, 1);
    end
    chk("pf_busy_held", bad, 0);
`else
      if (c <= 258 && s_ready) bad++;
      if (c == 259) begin
        chk("bp_ready_259", s_ready, 1);
        chk("bp_done_259", frame_done, 1);
        chk("bp_count_259", frame_count, 5);
      end
      if (c == 260) begin
        s_valid = 1'b0;
        chk("bp_start_260", enc_start, 1);
        chk("bp_data_260", enc_data, 8'h22);
      end
      if (c == 261) chk("bp_txv_261", tx_bit_valid, 0);
      if (c == 262) chk("bp_txv_262", tx_bit_valid, 1);
    end
    chk("bp_ready_low", bad, 0);
`endif
    wait_done(300, 16'd6);

    // Reset lands in bit 7 (cycles 115..130).
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'h77; enc_code = 12'h0F0;
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      if (c == 1) s_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_txv", tx_bit_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_count", frame_count, 0);
    chk("mrst_done", frame_done, 0);
    chk("mrst_ready", s_ready, 0);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (frame_done || busy) bad++;
    end
    chk("mrst_quiet", bad, 0);
    run_frame(8'h77, 12'h0F0, 16'hB0F0, 16'd1);

    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    chk("preload", frame_count, 16'hFFFF);
    run_frame(8'h3C, 12'h9E1, 16'hB9E1, 16'h0000);

    // Idle-gap instance: 2 silent bit periods after the frame.
    @(negedge clk);
    g_s_valid = 1'b1; g_s_data = 8'h5A;
    bad = 0; ticks = 0;
    for (int c = 1; c <= 292; c++) begin
      @(negedge clk);
      if (c == 1) g_s_valid = 1'b0;
      if (c == 258) chk("gap_txv_258", g_tx_bit_valid, 1);
      if (c == 259) chk("gap_no_done_259", g_frame_done, 0);
      if (c >= 259 && c <= 290) begin
        if (g_tx_bit || g_tx_bit_valid || g_frame_done || !g_busy) bad++;
        if (g_bit_tick) ticks++;
      end
      if (c == 291) begin
        chk("gap_done_291", g_frame_done, 1);
        chk("gap_count", g_frame_count, 1);
      end
    end
    chk("gap_quiet", bad, 0);
    chk("gap_ticks", ticks, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tx_frame_scheduler.md
Name: tx_frame_scheduler

Overview:
Transmit-side sequencer for the PCM -> Hamming -> frame -> FSK chain. It accepts 8-bit samples over a valid/ready handshake and launches the PCM/Hamming encoder with a start strobe. After the encoder's fixed latency it captures the 12-bit codeword, prepends the sync word into a 16-bit frame, and serialises the frame MSB-first to the FSK modulator at BIT_DIV clocks per bit. It sits between the sample source and the modulator and owns all transmit timing.

Parameters:
BIT_DIV, 16, sys_clk cycles per transmitted bit (must be >= 2).
PIPE_LAT, 2, encoder cycles from enc_start to a valid enc_code (must be >= 1).
IDLE_BITS, 0, bit periods of silence inserted after each frame.
SYNC_WORD, 4'b1011, frame header (frame bits 15:12).

Ports:
sys_clk  in  1  clock
sys_rst  in  1  synchronous reset, active-high
s_valid  in  1  sample valid
s_ready  out  1  scheduler can accept a sample
s_data  in  8  sample
enc_start  out  1  one-cycle pulse that launches the encoder
enc_data  out  8  registered sample, held stable until the next accept
enc_code  in  12  Hamming codeword from the encoder
tx_bit  out  1  serial bit to the FSK modulator
tx_bit_valid  out  1  high while a frame bit is driven
bit_tick  out  1  pulse on the first cycle of each bit
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse at frame completion
frame_count  out  16  frames completed; wraps FFFF->0000

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0. s_ready is forced to 0 while sys_rst is high.
- A reset in any state aborts the current frame on the next edge. No frame_done is produced, and frame_count clears.
- States: IDLE, ENCODE, SHIFT, GAP.
- IDLE:
  - s_ready=1.
  - On s_valid&&s_ready at the edge ending cycle 0: latch s_data into enc_data, go to ENCODE.
- ENCODE:
  - enc_start=1 in the first ENCODE cycle only (cycle 1).
  - Stays PIPE_LAT cycles (cycles 1..PIPE_LAT).
  - At the edge ending cycle PIPE_LAT: load shift register = {SYNC_WORD, enc_code}, go to SHIFT.
- SHIFT:
  - From cycle PIPE_LAT+1, for 16*BIT_DIV cycles: tx_bit_valid=1 and tx_bit = shreg[15].
  - Each bit is held BIT_DIV cycles; bit_tick pulses on the first cycle of each bit.
  - The register shifts left at the end of each bit.
  - After bit 16: go to GAP if IDLE_BITS>0, else complete.
- GAP: tx_bit=0, tx_bit_valid=0, bit_tick still pulses per bit period; lasts IDLE_BITS*BIT_DIV cycles, then complete.
- Complete: next state IDLE. frame_done=1 and frame_count increments, both in the first IDLE cycle.
- Without the optional feature, at least one IDLE cycle separates frames.
- The bit divider restarts at 0 on every frame load, so there is no phase carry-over between frames.
- enc_code is sampled only at the capture edge; changes at any other time are ignored.

Optional Feature:
SCHED_PREFETCH_EN.
- Defined: a one-entry sample buffer.
  - s_ready = (state==IDLE) || !buf_full.
  - Accepts during ENCODE/SHIFT/GAP.
  - At frame completion with buf_full: frame_done and frame_count update as normal, the state goes directly to ENCODE (enc_start next cycle), and the buffer drains to enc_data.
  - With a continuously valid source this gives back-to-back frames with no IDLE cycle.
  - Reset empties the buffer.
- Undefined: there is no buffer and s_ready=1 only in IDLE.

Decomposition:
- Shared package comm_pkg holds:
  - SAMPLE_W=8, CODE_W=12, SYNC_W=4, FRAME_W=16;
  - the default SYNC_WORD;
  - the scheduler state encoding (IDLE/ENCODE/SHIFT/GAP).
- One sub-module, bit_timer: a BIT_DIV divider with sync clear, producing bit_tick and a bit-index count of 0..15.

Test Plan:
- Single frame (BIT_DIV=16, PIPE_LAT=2, stub enc_code=12'hABC, sample 8'h5A accepted at cycle 0) -> enc_start at cycle 1, enc_data=8'h5A; tx_bit_valid over cycles 3..258; bits 1011 1010 1011 1100; frame_done at cycle 259; frame_count=1.
- Back-pressure: s_valid held high during SHIFT (macro off) -> s_ready=0 until IDLE; second sample accepted in the frame_done cycle; the second frame starts 1 cycle later.
- IDLE_BITS=2 -> 32 cycles with tx_bit=0 and tx_bit_valid=0 after bit 16; frame_done delayed by 32 cycles; bit_tick pulses twice during GAP.
- Reset asserted mid-SHIFT (bit 7) -> next cycle: tx_bit_valid=0, busy=0, frame_count=0, no frame_done; a new sample afterwards produces a full, correct frame.
- Wrap: frame_count preloaded or run to 16'hFFFF, one more frame -> 16'h0000.
- SCHED_PREFETCH_EN, continuous s_valid -> second sample accepted during SHIFT; frames separated by exactly PIPE_LAT+1 non-transmit cycles; no IDLE cycle; busy stays 1.
